// File: rtl/rv32_mul_div_seq.sv
// RV32M/RV64M multiply/divide/remainder unit: fixed-latency multiply, radix-2 restoring divide,
// 1-cycle special-case divides. Optional divide result reuse cache under `MUL_DIV_REUSE_EN.
module rv32_mul_div_seq #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic [TAG_W-1:0]  rd_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  rd_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: an op is accepted on a rising edge where start_i & ready_o & ~flush_i;
  // done_o is a one-cycle pulse with result_o/rd_o valid, and they hold until the next accept.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = 7;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_state_next;

  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a, r_b;
  logic [TAG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_result;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN:0]    r_rem;
  logic [XLEN-1:0]  r_div;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_finish, w_signed;
  logic             w_div_zero, w_div_ovf, w_hit, w_special;
  logic [XLEN-1:0]  w_hit_res, w_special_res, w_mul_res, w_fin_res;
  logic [XLEN+1:0]  w_rem_sh, w_diff;
  logic             w_q_bit;
  logic [XLEN-1:0]  w_quo_fix, w_rem_fix;
  logic             w_a_neg, w_b_neg;

  function automatic logic [XLEN-1:0] mul_res(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN:0]     ae, be;
    logic signed [2*XLEN+1:0] p;
    ae = {((op == 3'b001) || (op == 3'b010)) & a[XLEN-1], a};
    be = {(op == 3'b001) & b[XLEN-1], b};
    p  = ae * be;
    return (op == 3'b000) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign ready_o     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy_o      = (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign rd_o        = r_rd;
  assign dbg_state_o = r_state;

  assign w_accept   = start_i & ready_o & ~flush_i;
  assign w_signed   = ~r_op[0];
  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = w_signed & (r_a == INT_MIN) & (r_b == '1);
  assign w_special  = w_div_zero | w_div_ovf | w_hit;
  assign w_mul_res  = mul_res(r_op, r_a, r_b);

  assign w_a_neg = w_signed & r_a[XLEN-1];
  assign w_b_neg = w_signed & r_b[XLEN-1];

  // The dividend shifts out of the top of r_quo while quotient bits shift in at the bottom.
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {2'b00, r_div};
  assign w_q_bit   = ~w_diff[XLEN+1];
  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)     w_special_res = r_op[1] ? r_a : '1;
    else if (w_div_ovf) w_special_res = r_op[1] ? '0 : r_a;
    else if (w_hit)     w_special_res = w_hit_res;
  end

  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    w_fin_res    = w_mul_res;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_next = op_i[2] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == MUL_LAST) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end
      end
      S_DIV: begin
        w_fin_res = r_op[1] ? w_rem_fix : w_quo_fix;
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if ((r_cnt == '0) && w_special) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
          w_fin_res    = w_special_res;
        end else if (r_cnt == DIV_LAST) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) r_result <= w_fin_res;
      if (w_accept) begin
        r_op  <= op_i;
        r_a   <= operand_a_i;
        r_b   <= operand_b_i;
        r_rd  <= rd_i;
        r_cnt <= op_i[2] ? CW'(0) : CW'(1);
      end else if (busy_o && !flush_i) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_state == S_DIV) begin
          if (r_cnt == '0) begin
            r_quo   <= w_a_neg ? -r_a : r_a;
            r_div   <= w_b_neg ? -r_b : r_b;
            r_rem   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end else if (r_cnt != DIV_LAST) begin
            r_rem <= w_q_bit ? w_diff[XLEN:0] : w_rem_sh[XLEN:0];
            r_quo <= {r_quo[XLEN-2:0], w_q_bit};
          end
        end
      end
    end
  end

`ifdef MUL_DIV_REUSE_EN
  logic            r_c_valid, r_c_signed;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem;

  assign w_hit     = r_c_valid & (r_a == r_c_a) & (r_b == r_c_b) & (w_signed == r_c_signed);
  assign w_hit_res = r_op[1] ? r_c_rem : r_c_quo;

  // Only full-latency divides are stored; special cases are already single-cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c_valid  <= 1'b0;
      r_c_signed <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_quo    <= '0;
      r_c_rem    <= '0;
    end else if ((r_state == S_DIV) && w_finish && (r_cnt == DIV_LAST)) begin
      r_c_valid  <= 1'b1;
      r_c_signed <= w_signed;
      r_c_a      <= r_a;
      r_c_b      <= r_b;
      r_c_quo    <= w_quo_fix;
      r_c_rem    <= w_rem_fix;
    end else if ((w_accept && !op_i[2]) || (flush_i && busy_o)) begin
      r_c_valid  <= 1'b0;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

endmodule

// File: doc/rv32_mul_div_seq.md
Name: rv32_mul_div_seq

Overview:
Parametrised successor to the core's single-op M-extension unit. Executes RV32M/RV64M-style multiply, divide and remainder operations:
- Multiplies use a configurable-depth pipeline.
- Divides use an iterative radix-2 engine.
- Divide-by-zero and signed-overflow cases take a 1-cycle fast path.
Sits beside the execute stage. The hazard unit uses ready_o/busy_o and rd_o for stalling and forwarding; writeback consumes done_o/result_o/rd_o.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiply latency in cycles from accept to done (1..4)
TAG_W, 5, destination register tag width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset
start_i  in  1  request; accepted only when ready_o=1
op_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  in  XLEN  rs1 value (multiplicand/dividend)
operand_b_i  in  XLEN  rs2 value (multiplier/divisor)
rd_i  in  TAG_W  destination tag, captured on accept
flush_i  in  1  abort in-flight op (branch/exception flush)
ready_o  out  1  unit can accept start this cycle
busy_o  out  1  op in flight (state MUL or DIV)
done_o  out  1  one-cycle result-valid pulse
result_o  out  XLEN  result; held stable until next accept
rd_o  out  TAG_W  tag of in-flight/last op

Behaviour:
- Clocking/reset: one clock, clk_i. Synchronous, active-high reset rst_i.
- Reset: state=IDLE; ready_o=1; busy_o=0; done_o=0; result_o=0; rd_o=0. A reset mid-operation discards the op, with no done_o.
- States: IDLE, MUL, DIV, DONE. ready_o=1 in IDLE and DONE; busy_o=1 in MUL and DIV.
- Accept: start_i & ready_o at edge E0 captures op, operands and rd_i. A start while busy is ignored, with no side effect.
- Multiply: MUL -> state MUL. done_o asserts in the cycle MUL_STAGES edges after E0, then state goes to DONE.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide: DIV -> state DIV. Sequence is 1 setup cycle (absolute values, sign record), XLEN iterations, then 1 sign-fixup cycle. done_o asserts XLEN+2 cycles after E0.
  - Quotient truncates toward zero.
  - Remainder sign follows the dividend.
- Divide-by-zero (b=0): quotient = all ones; remainder = a. done_o is 1 cycle after E0.
- Signed overflow (DIV/REM, a=-2^(XLEN-1), b=-1): quotient = a; remainder = 0. done_o is 1 cycle after E0.
- DONE: done_o pulses for exactly 1 cycle; state then remains DONE (result/rd held) until the next accept.
  - A start in the same cycle as done_o is legal: back-to-back, and the new op begins next edge.
- flush_i: at the next edge, state -> IDLE with no done_o. result_o keeps its last completed value.
  - flush_i and start_i in the same cycle: flush wins and the start is dropped.
  - flush_i in DONE/IDLE has no effect.
- Arithmetic is internally width-safe: the product is 2*XLEN+2 bits (sign-extended operands); the divider remainder register is XLEN+1 bits.

Optional Feature:
Macro MUL_DIV_REUSE_EN.
- Defined: the unit keeps the operands, signedness and both quotient and remainder of the last completed divide. A later DIV/REM (or DIVU/REMU) with identical operands and matching signedness completes 1 cycle after accept, returning the stored quotient/remainder. Any multiply, flush or reset invalidates the cache.
- Undefined: the cache logic is absent and every divide takes the full latency.

Test Plan:
1. Reset held 2 cycles, then released -> ready_o=1, busy_o=0, done_o=0, result_o=0.
2. MULH a=0x80000000 b=0x80000000 rd=3, MUL_STAGES=2 -> done_o 2 cycles after accept, result_o=0x40000000, rd_o=3. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> done_o 34 cycles after accept, result_o=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF (34 cycles; 1 cycle with MUL_DIV_REUSE_EN).
4. DIVU a=5 b=0 -> result_o=0xFFFFFFFF at 1 cycle. REM a=0x80000000 b=0xFFFFFFFF -> result_o=0 at 1 cycle.
5. DIV a=100 b=7, flush_i at cycle 10 -> no done_o, ready_o=1 next cycle, result_o unchanged. Then DIV 100/7 -> 14.
6. Start during DIV busy -> ignored. Start coincident with done_o -> second op accepted, its done_o at the correct latency.
